// File: rtl/multiplier_datapath_taint_track.sv
// Shift-add datapath for the sequential multiplier with per-bit taint shadows.
// Executes controller strobes on MD/MR/RS; RS bit 2*WIDTH holds the add carry.
module multiplier_datapath_taint_track #(
  parameter int WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplicand_t,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [WIDTH-1:0]     multiplier_t,
  input  logic                 rsload,
  input  logic                 rsclear,
  input  logic                 rsshr,
  input  logic                 mrld,
  input  logic                 mdld,
  input  logic                 rsload_t,
  input  logic                 rsclear_t,
  input  logic                 rsshr_t,
  input  logic                 mrld_t,
  input  logic                 mdld_t,
  output logic [WIDTH-1:0]     multiplierReg,
  output logic [WIDTH-1:0]     multiplierReg_t,
  output logic [2*WIDTH-1:0]   product,
  output logic [2*WIDTH-1:0]   product_t
);

  logic [WIDTH-1:0]   md_q, md_d, md_t_q, md_t_d;
  logic [WIDTH-1:0]   mr_q, mr_d, mr_t_q, mr_t_d;
  logic [2*WIDTH:0]   rs_q, rs_d, rs_t_q, rs_t_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   add_o_t;
  logic [WIDTH-1:0]   sum_t;
  logic               carry_t;

  always_comb begin
    md_d   = md_q;
    md_t_d = md_t_q;
    if (mdld) begin
      md_d   = multiplicand;
      md_t_d = multiplicand_t;
    end
    if (mdld_t) md_t_d = '1;

    mr_d   = mr_q;
    mr_t_d = mr_t_q;
    if (mrld) begin
      mr_d   = multiplier;
      mr_t_d = multiplier_t;
    end
    if (mrld_t) mr_t_d = '1;
  end

  // Conservative ripple-carry taint: a sum bit is tainted if any lower operand bit is.
  always_comb begin
    logic run;
    sum     = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};
    add_o_t = rs_t_q[2*WIDTH-1:WIDTH] | md_t_q;
    run     = 1'b0;
    sum_t   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      run      = run | add_o_t[i];
      sum_t[i] = run;
    end
    carry_t = run;
  end

  always_comb begin
    rs_d   = rs_q;
    rs_t_d = rs_t_q;
    if (rsclear) begin
      rs_d   = '0;
      rs_t_d = '0;
    end else if (rsload) begin
      rs_d[2*WIDTH:WIDTH]   = sum;
      rs_t_d[2*WIDTH:WIDTH] = {carry_t, sum_t};
    end else if (rsshr) begin
      rs_d   = rs_q >> 1;
      rs_t_d = rs_t_q >> 1;
    end
    if (rsclear_t || rsload_t || rsshr_t) rs_t_d = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      md_q   <= '0;
      md_t_q <= '0;
      mr_q   <= '0;
      mr_t_q <= '0;
      rs_q   <= '0;
      rs_t_q <= '0;
    end else begin
      md_q   <= md_d;
      md_t_q <= md_t_d;
      mr_q   <= mr_d;
      mr_t_q <= mr_t_d;
      rs_q   <= rs_d;
      rs_t_q <= rs_t_d;
    end
  end

  assign multiplierReg   = mr_q;
  assign multiplierReg_t = mr_t_q;
  assign product         = rs_q[2*WIDTH-1:0];
  assign product_t       = rs_t_q[2*WIDTH-1:0];

endmodule

// File: tb/tb_multiplier_datapath_taint_track.sv
// Directed bench for the taint-tracking multiplier datapath at WIDTH=4,
// replaying the controller's strobe sequence with hand-computed results.
module tb_multiplier_datapath_taint_track;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   multiplicand = '0, multiplicand_t = '0;
  logic [W-1:0]   multiplier = '0, multiplier_t = '0;
  logic           rsload = 0, rsclear = 0, rsshr = 0, mrld = 0, mdld = 0;
  logic           rsload_t = 0, rsclear_t = 0, rsshr_t = 0, mrld_t = 0, mdld_t = 0;
  logic [W-1:0]   multiplierReg, multiplierReg_t;
  logic [2*W-1:0] product, product_t;

  int checks = 0;
  int failures = 0;

  multiplier_datapath_taint_track #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
    .multiplier(multiplier), .multiplier_t(multiplier_t),
    .rsload(rsload), .rsclear(rsclear), .rsshr(rsshr), .mrld(mrld), .mdld(mdld),
    .rsload_t(rsload_t), .rsclear_t(rsclear_t), .rsshr_t(rsshr_t),
    .mrld_t(mrld_t), .mdld_t(mdld_t),
    .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
    .product(product), .product_t(product_t)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic rc, input logic rl, input logic rs_, input logic mr, input logic md);
    rsclear = rc; rsload = rl; rsshr = rs_; mrld = mr; mdld = md;
    @(posedge clk);
    #1;
    rsclear = 0; rsload = 0; rsshr = 0; mrld = 0; mdld = 0;
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    multiplicand = a;
    multiplier   = b;
    cyc(1, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < W; i++) begin
      if (b[i]) cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset_product", {8'h0, product}, 16'h0);
    chk("reset_product_t", {8'h0, product_t}, 16'h0);
    chk("reset_mr", {12'h0, multiplierReg}, 16'h0);
    rst = 1'b1;

    run_mult(4'd13, 4'd11);
    chk("13x11_product", {8'h0, product}, 16'h008F);
    chk("13x11_product_t", {8'h0, product_t}, 16'h0);
    chk("13x11_mr_t", {12'h0, multiplierReg_t}, 16'h0);
    chk("13x11_mr", {12'h0, multiplierReg}, 16'h000B);

    run_mult(4'd15, 4'd15);
    chk("15x15_product", {8'h0, product}, 16'h00E1);

    run_mult(4'd0, 4'd9);
    chk("0x9_product", {8'h0, product}, 16'h0);

    // 13*11 with MD taint bit 2; bench-computed taint after each step.
    multiplicand_t = 4'b0100;
    multiplicand = 4'd13;
    multiplier   = 4'd11;
    cyc(1, 0, 0, 1, 1);
    multiplicand_t = 4'b0000;
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("taint_first_load", {8'h0, product_t}, 16'h00C0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("taint_final_product_t", {8'h0, product_t}, 16'h00FC);
    chk("taint_final_product", {8'h0, product}, 16'h008F);

    // Tainted shift strobe with no strobe asserted.
    multiplicand = 4'd13;
    cyc(1, 0, 0, 1, 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("pre_rsshr_t_product", {8'h0, product}, 16'h00D0);
    rsshr_t = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rsshr_t = 1'b0;
    chk("rsshr_t_product_t", {8'h0, product_t}, 16'h00FF);
    chk("rsshr_t_mr_t", {12'h0, multiplierReg_t}, 16'h0);
    chk("rsshr_t_product_hold", {8'h0, product}, 16'h00D0);

    // Reset during the third shift of 13*11.
    multiplier_t = 4'b0010;
    cyc(1, 0, 0, 1, 1);
    multiplier_t = 4'b0000;
    chk("mr_t_loaded", {12'h0, multiplierReg_t}, 16'h0002);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("mid_run_product", {8'h0, product}, 16'h0138 & 16'h00FF);
    rst = 1'b0;
    cyc(0, 0, 1, 0, 0);
    rst = 1'b1;
    chk("rst_mid_product", {8'h0, product}, 16'h0);
    chk("rst_mid_product_t", {8'h0, product_t}, 16'h0);
    chk("rst_mid_mr", {12'h0, multiplierReg}, 16'h0);
    chk("rst_mid_mr_t", {12'h0, multiplierReg_t}, 16'h0);

    // Tainted mrld strobe that does not fire: taint set, value held.
    mrld_t = 1'b1;
    cyc(0, 0, 0, 0, 0);
    mrld_t = 1'b0;
    chk("mrld_t_only_mr_t", {12'h0, multiplierReg_t}, 16'h000F);
    chk("mrld_t_only_mr", {12'h0, multiplierReg}, 16'h0);

    // Strobe priority.
    run_mult(4'd13, 4'd11);
    chk("prio_pre_product", {8'h0, product}, 16'h008F);
    cyc(1, 1, 1, 0, 0);
    chk("prio_clear_wins", {8'h0, product}, 16'h0);
    cyc(0, 1, 1, 0, 0);
    chk("prio_load_over_shift", {8'h0, product}, 16'h00D0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_datapath_taint_track.md
# multiplier_datapath_taint_track

Shift-add datapath for the sequential multiplier, with taint tracking. It sits on the opposite side of the control interface from the multiplier controller. It executes the controller's load, clear, shift and add strobes on the multiplicand, multiplier and result-shift registers, and returns the multiplier register, plus its taint, to the controller for bit tests. Every data register has a shadow taint register of equal width, updated every cycle by the propagation rules below.

## Interface
- WIDTH, 1024: operand width in bits; product is 2*WIDTH bits
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge clears all state)
- multiplicand  input  WIDTH  operand A, captured on mdld
- multiplicand_t  input  WIDTH  taint of operand A
- multiplier  input  WIDTH  operand B, captured on mrld
- multiplier_t  input  WIDTH  taint of operand B
- rsload, rsclear, rsshr, mrld, mdld  input  1 each  control strobes from controller
- rsload_t, rsclear_t, rsshr_t, mrld_t, mdld_t  input  1 each  taint of each strobe
- multiplierReg  output  WIDTH  current multiplier register (to controller)
- multiplierReg_t  output  WIDTH  its taint
- product  output  2*WIDTH  RS[2*WIDTH-1:0]
- product_t  output  2*WIDTH  taint of product

## Operation
- Registers:
  - MD[WIDTH-1:0], MR[WIDTH-1:0], RS[2*WIDTH:0] (bit 2*WIDTH is the carry).
  - Each has a taint twin: MD_t, MR_t, RS_t.
- Reset (rst==0): all six registers become 0. This has priority over every strobe, including mid-multiplication. All outputs read 0 the cycle after.
- mdld:
  - MD<=multiplicand and MD_t<=multiplicand_t.
  - If mdld_t, MD_t<=all ones.
- mrld: same as mdld, applied to MR/multiplier.
- mdld_t with mdld==0: MD_t<=MD_t | all ones. A tainted strobe taints the target whether or not it fires. The same rule holds for every strobe/register pair.
- RS strobes, priority rsclear > rsload > rsshr; only the highest asserted one acts:
  - rsclear: RS<=0, RS_t<=0.
  - rsload: RS[2*WIDTH:WIDTH] <= RS[2*WIDTH-1:WIDTH] + MD, a (WIDTH+1)-bit sum with the carry into bit 2*WIDTH. RS[WIDTH-1:0] is unchanged.
  - rsshr: RS<=RS>>1, with the MSB filled with 0.
- Taint propagation for rsload:
  - Let o[i] = RS_t[WIDTH+i] | MD_t[i] for i in 0..WIDTH-1.
  - Sum-bit taint s_t[i] = OR of o[0..i] (conservative ripple carry). Carry-bit taint = OR of all o.
  - The lower half of RS_t is unchanged.
- Taint for rsshr: RS_t shifts with RS; the MSB fills with 0.
- Taint for rsclear: RS_t<=0.
- Tainted RS strobes: if any of rsclear_t, rsload_t or rsshr_t is 1, RS_t<=all ones that cycle. This overrides the rules above, and applies whether or not any strobe is asserted.
- Outputs are direct register reads with no combinational path from inputs: multiplierReg=MR, product=RS[2*WIDTH-1:0], and likewise for the taints.
- Arithmetic across the controller's sequence:
  - INIT clears RS and loads both operands.
  - WIDTH+1 shifts follow, with one rsload inserted before each shift for every set multiplier bit.
  - The first shift acts on zero. After the final shift, product = MD*MR exactly, and no overflow is possible.

## Timing
- Every strobe takes effect at the rising edge where it is sampled high. Results are visible one cycle later.
- Controller protocol, counted in cycles after the INIT edge:
  - One cycle per shift and one per load.
  - Total 1 + (WIDTH+1) + popcount(MR) cycles including INIT.
  - The controller's productDone is high during the final shift cycle. product is valid from the next cycle and holds until the next rsclear, rsload or rsshr.
- MR bit n is stable from the cycle after mrld until the next mrld. The controller indexes it combinationally.
- Simultaneous strobes are resolved by the priority above. mdld and mrld may coincide with each other and with any RS strobe.

## Test plan
- WIDTH=4, multiplicand=13, multiplier=11, driven with the controller's exact strobe sequence:
  - Expected: product=0x008F (143) the cycle after the final shift.
  - All taint outputs 0.
- WIDTH=4, 15*15 -> product=0x00E1 (225). This checks that the carry bit is absorbed on each shift. Also 0*9 -> product=0, with zero loads issued.
- WIDTH=4, 13*11, multiplicand_t=4'b0100 on mdld:
  - After the first rsload, RS_t[2*WIDTH:WIDTH] = 5'b11100.
  - Final product_t must be nonzero in bits [6:2] and 0 in bits [1:0].
- rsshr_t=1 for one cycle mid-sequence -> RS_t all ones the next cycle. multiplierReg_t is unaffected.
- rst=0 asserted during the third shift of a 13*11 run -> the next cycle, product, multiplierReg and all taints are 0.
- rsclear, rsload and rsshr asserted together with RS nonzero -> RS=0 next cycle, so clear wins. Then rsload and rsshr together -> only the add occurs.
